// File: rtl/exc_pkg.sv
// Shared types and defaults for the TLB-miss trap controller.
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER_FLUSH,
        ST_ENTER_REDIR,
        ST_HANDLER,
        ST_RET_FLUSH,
        ST_RET_REDIR,
        ST_HALT
    } exc_state_t;

    typedef enum logic {
        CAUSE_ITLB = 1'b0,
        CAUSE_DTLB = 1'b1
    } exc_cause_t;

    localparam logic [31:0] HANDLER_VECTOR_DEFAULT = 32'h0000_2000;
    localparam int          FLUSH_CYCLES_DEFAULT   = 3;

endpackage

// File: rtl/exc_flush_timer.sv
// Load/decrement down-counter that times the flush window on trap entry and return.
module exc_flush_timer #(
    parameter int FLUSH_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(FLUSH_CYCLES - 1);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/tlb_exception_ctrl.sv
// TLB-miss trap sequencer: arbitrates i/d misses, flushes, redirects to the handler and back on IRET.
module tlb_exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_VECTOR = HANDLER_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES   = FLUSH_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        itlb_miss,
    input  logic [31:0] itlb_pc,
    input  logic        dtlb_miss,
    input  logic [31:0] dtlb_pc,
    input  logic [31:0] dtlb_vaddr,
    input  logic        iret_req,
    input  logic [31:0] epc_in,
    output logic        tlb_miss,
    output logic [31:0] tlb_pc_reg,
    output logic [31:0] tlb_addr_reg,
    output logic        iret,
    output logic        exc_cause,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        double_fault
);

    exc_state_t state_q, state_d;
    exc_cause_t cause_q, cause_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, epc_q, epc_d;
    logic        timer_load, timer_dec, timer_done;

    logic        tlb_miss_q, tlb_miss_d, iret_q, iret_d;
    logic        flush_q, flush_d, stall_q, stall_d;
    logic        redir_q, redir_d, dfault_q, dfault_d;
    logic [31:0] target_q, target_d;

    exc_flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .dec   (timer_dec),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus fault/EPC capture; dTLB wins because its instruction is older.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        epc_d   = epc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dtlb_miss) begin
                    state_d = ST_ENTER_FLUSH;
                    cause_d = CAUSE_DTLB;
                    pc_d    = dtlb_pc;
                    addr_d  = dtlb_vaddr;
                end else if (itlb_miss) begin
                    state_d = ST_ENTER_FLUSH;
                    cause_d = CAUSE_ITLB;
                    pc_d    = itlb_pc;
                    addr_d  = itlb_pc;
                end
            end
            ST_ENTER_FLUSH: if (timer_done) state_d = ST_ENTER_REDIR;
            ST_ENTER_REDIR: state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (dtlb_miss || itlb_miss) begin
                    state_d = ST_HALT;
                end else if (iret_req) begin
                    state_d = ST_RET_FLUSH;
                    epc_d   = epc_in;
                end
            end
            ST_RET_FLUSH:   if (timer_done) state_d = ST_RET_REDIR;
            ST_RET_REDIR:   state_d = ST_IDLE;
            ST_HALT:        state_d = ST_HALT;
            default:        state_d = ST_IDLE;
        endcase
    end

    assign timer_load = ((state_q == ST_IDLE)    && (state_d == ST_ENTER_FLUSH)) ||
                        ((state_q == ST_HANDLER) && (state_d == ST_RET_FLUSH));
    assign timer_dec  = (state_q == ST_ENTER_FLUSH) || (state_q == ST_RET_FLUSH);

    // Outputs are decoded from the upcoming state so every port comes straight from a flop.
    always_comb begin
        tlb_miss_d = (state_q == ST_IDLE) && (state_d == ST_ENTER_FLUSH);
        iret_d     = (state_q == ST_HANDLER) && (state_d == ST_RET_FLUSH);
        flush_d    = (state_d == ST_ENTER_FLUSH) || (state_d == ST_RET_FLUSH);
        stall_d    = flush_d || (state_d == ST_HALT);
        redir_d    = (state_d == ST_ENTER_REDIR) || (state_d == ST_RET_REDIR);
        dfault_d   = dfault_q || (state_d == ST_HALT);
        target_d   = target_q;
        if (state_d == ST_ENTER_REDIR) begin
            target_d = HANDLER_VECTOR;
        end else if (state_d == ST_RET_REDIR) begin
            target_d = epc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q    <= CAUSE_ITLB;
            pc_q       <= '0;
            addr_q     <= '0;
            epc_q      <= '0;
            tlb_miss_q <= 1'b0;
            iret_q     <= 1'b0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            redir_q    <= 1'b0;
            dfault_q   <= 1'b0;
            target_q   <= '0;
        end else begin
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            epc_q      <= epc_d;
            tlb_miss_q <= tlb_miss_d;
            iret_q     <= iret_d;
            flush_q    <= flush_d;
            stall_q    <= stall_d;
            redir_q    <= redir_d;
            dfault_q   <= dfault_d;
            target_q   <= target_d;
        end
    end

    assign tlb_miss     = tlb_miss_q;
    assign tlb_pc_reg   = pc_q;
    assign tlb_addr_reg = addr_q;
    assign iret         = iret_q;
    assign exc_cause    = cause_q;
    assign flush        = flush_q;
    assign stall        = stall_q;
    assign pc_redirect  = redir_q;
    assign pc_target    = target_q;
    assign double_fault = dfault_q;

endmodule

// File: tb/tb_tlb_exception_ctrl.sv
// Scoreboard bench for tlb_exception_ctrl: directed traps/returns, expected pulses queued and checked by a monitor.
module tb_tlb_exception_ctrl;

    localparam int EV_MISS  = 0;
    localparam int EV_IRET  = 1;
    localparam int EV_REDIR = 2;

    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        cause;
        logic [31:0] target;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        itlb_miss = 1'b0, dtlb_miss = 1'b0, iret_req = 1'b0;
    logic [31:0] itlb_pc = '0, dtlb_pc = '0, dtlb_vaddr = '0, epc_in = '0;
    logic        tlb_miss, iret, exc_cause, flush, stall, pc_redirect, double_fault;
    logic [31:0] tlb_pc_reg, tlb_addr_reg, pc_target;

    int  checks = 0;
    int  errors = 0;
    ev_t expq[$];

    tlb_exception_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .itlb_miss    (itlb_miss),
        .itlb_pc      (itlb_pc),
        .dtlb_miss    (dtlb_miss),
        .dtlb_pc      (dtlb_pc),
        .dtlb_vaddr   (dtlb_vaddr),
        .iret_req     (iret_req),
        .epc_in       (epc_in),
        .tlb_miss     (tlb_miss),
        .tlb_pc_reg   (tlb_pc_reg),
        .tlb_addr_reg (tlb_addr_reg),
        .iret         (iret),
        .exc_cause    (exc_cause),
        .flush        (flush),
        .stall        (stall),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .double_fault (double_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs starting just after a rising edge, then returns inputs to idle.
    task automatic applyStimulus(input logic im, input logic [31:0] ipc,
                                 input logic dm, input logic [31:0] dpc, input logic [31:0] dva,
                                 input logic ir, input logic [31:0] epc);
        itlb_miss = im; itlb_pc = ipc;
        dtlb_miss = dm; dtlb_pc = dpc; dtlb_vaddr = dva;
        iret_req = ir;  epc_in = epc;
        @(posedge clk); #1;
        itlb_miss = 1'b0; itlb_pc = '0;
        dtlb_miss = 1'b0; dtlb_pc = '0; dtlb_vaddr = '0;
        iret_req = 1'b0;  epc_in = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushEv(input int kind, input logic [31:0] pc, input logic [31:0] addr,
                          input logic cause, input logic [31:0] target);
        ev_t e;
        e.kind = kind; e.pc = pc; e.addr = addr; e.cause = cause; e.target = target;
        expq.push_back(e);
    endtask

    task automatic countFlush(input string name, input int exp);
        int cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (flush) cnt++;
        end
        @(posedge clk); #1;
        checkOutput(name, cnt, exp);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tlb_miss"}, {31'b0, tlb_miss}, 0);
        checkOutput({tag, "_iret"}, {31'b0, iret}, 0);
        checkOutput({tag, "_flush"}, {31'b0, flush}, 0);
        checkOutput({tag, "_stall"}, {31'b0, stall}, 0);
        checkOutput({tag, "_redirect"}, {31'b0, pc_redirect}, 0);
        checkOutput({tag, "_double_fault"}, {31'b0, double_fault}, 0);
        checkOutput({tag, "_cause"}, {31'b0, exc_cause}, 0);
        checkOutput({tag, "_pc_reg"}, tlb_pc_reg, 0);
        checkOutput({tag, "_addr_reg"}, tlb_addr_reg, 0);
        checkOutput({tag, "_pc_target"}, pc_target, 0);
    endtask

    // Monitor: any pulse the DUT presents must match the head of the expectation queue.
    initial begin
        ev_t e;
        int  kind;
        forever begin
            @(negedge clk);
            if (!reset && (tlb_miss || iret || pc_redirect)) begin
                kind = tlb_miss ? EV_MISS : (iret ? EV_IRET : EV_REDIR);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_event: got kind %0d, expected no event", kind);
                end else begin
                    e = expq.pop_front();
                    checkOutput("event_kind", kind, e.kind);
                    case (e.kind)
                        EV_MISS: begin
                            checkOutput("miss_pc", tlb_pc_reg, e.pc);
                            checkOutput("miss_addr", tlb_addr_reg, e.addr);
                            checkOutput("miss_cause", {31'b0, exc_cause}, {31'b0, e.cause});
                            checkOutput("miss_flush", {31'b0, flush & stall}, 1);
                        end
                        EV_IRET: begin
                            checkOutput("iret_flush", {31'b0, flush & stall}, 1);
                        end
                        default: begin
                            checkOutput("redir_target", pc_target, e.target);
                            checkOutput("redir_noflush", {30'b0, flush, stall}, 0);
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;
        tick(2);

        // iTLB miss, then return to the faulting PC
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        pushEv(EV_MISS, 32'h100, 32'h100, 1'b0, 0);
        pushEv(EV_REDIR, 0, 0, 1'b0, 32'h2000);
        countFlush("t1_flush_len", 3);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h100);
        pushEv(EV_IRET, 0, 0, 1'b0, 0);
        pushEv(EV_REDIR, 0, 0, 1'b0, 32'h100);
        countFlush("t1_ret_flush_len", 3);

        // simultaneous misses: dTLB wins; extra miss/iret during entry flush ignored
        applyStimulus(1, 32'h208, 1, 32'h204, 32'h8000_0010, 0, 0);
        pushEv(EV_MISS, 32'h204, 32'h8000_0010, 1'b1, 0);
        pushEv(EV_REDIR, 0, 0, 1'b0, 32'h2000);
        applyStimulus(1, 32'h999, 0, 0, 0, 1, 32'hdead);
        countFlush("t5_flush_remaining", 2);
        checkOutput("t5_pc_held", tlb_pc_reg, 32'h204);
        checkOutput("t5_addr_held", tlb_addr_reg, 32'h8000_0010);
        checkOutput("t5_cause_held", {31'b0, exc_cause}, 1);

        // IRET back to saved EPC, then IRET in IDLE is ignored
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h204);
        pushEv(EV_IRET, 0, 0, 1'b0, 0);
        pushEv(EV_REDIR, 0, 0, 1'b0, 32'h204);
        countFlush("t3_ret_flush_len", 3);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h777);
        tick(3);
        checkOutput("idle_iret_stall", {31'b0, stall}, 0);
        checkOutput("idle_iret_target", pc_target, 32'h204);

        // miss inside the handler halts with double fault
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0);
        pushEv(EV_MISS, 32'h300, 32'h300, 1'b0, 0);
        pushEv(EV_REDIR, 0, 0, 1'b0, 32'h2000);
        countFlush("t4_entry_flush_len", 3);
        applyStimulus(0, 0, 1, 32'h400, 32'h500, 1, 32'h111);
        tick(4);
        checkOutput("t4_double_fault", {31'b0, double_fault}, 1);
        checkOutput("t4_stall_stuck", {31'b0, stall}, 1);
        checkOutput("t4_flush", {31'b0, flush}, 0);
        checkOutput("t4_pc_held", tlb_pc_reg, 32'h300);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkAllZero("t4_reset");

        // reset on the second flush cycle aborts the entry
        applyStimulus(1, 32'h600, 0, 0, 0, 0, 0);
        pushEv(EV_MISS, 32'h600, 32'h600, 1'b0, 0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkAllZero("t6_reset");
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        pushEv(EV_MISS, 32'h100, 32'h100, 1'b0, 0);
        pushEv(EV_REDIR, 0, 0, 1'b0, 32'h2000);
        countFlush("t6_flush_len", 3);

        tick(3);
        checkOutput("queue_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
